// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Word-addressed data memory that answers a CPU EX/MEM stage over a shared
// tri-state data bus. After reset the array is zero-filled one word per cycle
// (INIT); the block then serves loads and stores (RUN) until the next reset.
//
// Ports
//   clk          : single clock, all state changes on rising edge
//   reset        : synchronous, active-high
//   daddrbus     : byte address; word index is daddrbus[ADDR_BITS+1:2]
//   databus      : shared bus; CPU drives on store, this block drives on load
//   load, store  : access requests for the current cycle
//   ready        : high only while in RUN
//   err_misalign : sticky, an access used daddrbus[1:0] != 0
//   err_range    : sticky, an access addressed beyond the array
//   err_conflict : sticky, load+store together or an access while not ready
//   load_count   : accepted loads, wraps silently
//   store_count  : accepted stores, wraps silently
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int unsigned ADDR_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddrbus,
  inout  wire  [31:0] databus,
  input  logic        load,
  input  logic        store,
  output logic        ready,
  output logic        err_misalign,
  output logic        err_range,
  output logic        err_conflict,
  output logic [15:0] load_count,
  output logic [15:0] store_count
);

  localparam int unsigned DEPTH     = 1 << ADDR_BITS;
  localparam int unsigned CNT_BITS  = 16;
  localparam int unsigned DATA_BITS = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [ADDR_BITS-1:0] init_idx;
  logic [DATA_BITS-1:0] mem [DEPTH];

  // Address decode
  logic [ADDR_BITS-1:0] index_c;
  logic                 in_range_c;
  logic                 misaligned_c;
  logic                 single_op_c;
  logic                 run_c;
  logic                 load_acc_c;
  logic                 store_acc_c;
  logic                 bus_drive_c;
  logic [DATA_BITS-1:0] rd_data_c;

  assign index_c      = daddrbus[ADDR_BITS+1:2];
  assign in_range_c   = (daddrbus[31:ADDR_BITS+2] == '0);
  assign misaligned_c = |daddrbus[1:0];
  assign single_op_c  = load ^ store;
  assign run_c        = (state == RUN);
  assign load_acc_c   = run_c && load  && !store && in_range_c;
  assign store_acc_c  = run_c && store && !load  && in_range_c;

  // Zero-latency read path; out-of-range loads return zero.
  assign bus_drive_c = run_c && load && !store;
  assign rd_data_c   = in_range_c ? mem[index_c] : '0;
  assign databus     = bus_drive_c ? rd_data_c : 'z;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: INIT runs until the last index is cleared, RUN is terminal.
  always_comb begin
    state_next = state;
    case (state)
      INIT: begin
        if (init_idx == ADDR_BITS'(DEPTH - 1)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: begin
        state_next = INIT;
      end
    endcase
  end

  // Ready is registered from the next state so it rises on the INIT->RUN edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready <= 1'b0;
    end else begin
      ready <= (state_next == RUN);
    end
  end

  // Zero-fill walker
  always_ff @(posedge clk) begin
    if (reset) begin
      init_idx <= '0;
    end else if (state == INIT) begin
      init_idx <= init_idx + ADDR_BITS'(1);
    end
  end

  // Storage: INIT clears one word per cycle, RUN commits accepted stores.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        mem[init_idx] <= '0;
      end else if (store_acc_c) begin
        mem[index_c] <= databus;
      end
    end
  end

  // Access counters
  always_ff @(posedge clk) begin
    if (reset) begin
      load_count  <= '0;
      store_count <= '0;
    end else begin
      if (load_acc_c) begin
        load_count <= load_count + CNT_BITS'(1);
      end
      if (store_acc_c) begin
        store_count <= store_count + CNT_BITS'(1);
      end
    end
  end

  // Sticky error flags; address faults are judged only on well-formed RUN accesses.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_misalign <= 1'b0;
      err_range    <= 1'b0;
      err_conflict <= 1'b0;
    end else begin
      if ((load && store) || ((load || store) && !run_c)) begin
        err_conflict <= 1'b1;
      end
      if (run_c && single_op_c && misaligned_c) begin
        err_misalign <= 1'b1;
      end
      if (run_c && single_op_c && !in_range_c) begin
        err_range <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Scoreboard bench: the driver applies one request per cycle, asks a
// behavioural model what the DUT must show during that cycle and queues it;
// a monitor on the falling edge pops each expectation and compares.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int unsigned AB    = 6;
  localparam int unsigned WORDS = 1 << AB;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] daddrbus;
  wire  [31:0] databus;
  logic        load;
  logic        store;
  logic        ready;
  logic        err_misalign;
  logic        err_range;
  logic        err_conflict;
  logic [15:0] load_count;
  logic [15:0] store_count;

  logic [31:0] cpu_data;
  logic        cpu_drive;

  assign databus = cpu_drive ? cpu_data : 'z;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_BITS(AB)) dut (
    .clk          (clk),
    .reset        (reset),
    .daddrbus     (daddrbus),
    .databus      (databus),
    .load         (load),
    .store        (store),
    .ready        (ready),
    .err_misalign (err_misalign),
    .err_range    (err_range),
    .err_conflict (err_conflict),
    .load_count   (load_count),
    .store_count  (store_count)
  );

  typedef struct {
    string       tag;
    logic        ready;
    logic [15:0] lc;
    logic [15:0] sc;
    logic        mis;
    logic        rng;
    logic        con;
    logic        drive;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model: what a CPU would observe, kept as plain variables.
  bit          m_known = 0;
  int          m_init_left;
  logic [31:0] m_mem [WORDS];
  logic [15:0] m_lc, m_sc;
  bit          m_mis, m_rng, m_con;

  function automatic bit m_ready();
    return m_known && (m_init_left == 0);
  endfunction

  task automatic chk(input string name, input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%s] got=%h expected=%h at %0t", name, tag, act, exp, $time);
    end
  endtask

  // Monitor: compare the queued expectation away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ready",        e.tag, 32'(ready),        32'(e.ready));
        chk("load_count",   e.tag, 32'(load_count),   32'(e.lc));
        chk("store_count",  e.tag, 32'(store_count),  32'(e.sc));
        chk("err_misalign", e.tag, 32'(err_misalign), 32'(e.mis));
        chk("err_range",    e.tag, 32'(err_range),    32'(e.rng));
        chk("err_conflict", e.tag, 32'(err_conflict), 32'(e.con));
        chk("bus_drive",    e.tag, 32'(dut.bus_drive_c), 32'(e.drive));
        if (e.drive) begin
          chk("load_data", e.tag, databus, e.data);
        end
      end
    end
  end

  // One bus cycle: drive inputs, queue what must be seen, advance the model.
  task automatic cyc(input string tag, input bit rst, input bit ld, input bit st,
                     input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    int          idx;
    bit          in_rng;
    @(posedge clk);
    #1;
    reset     = rst;
    load      = ld;
    store     = st;
    daddrbus  = addr;
    cpu_data  = wdata;
    cpu_drive = st;
    idx    = int'(addr[AB+1:2]);
    in_rng = (addr >> (AB + 2)) == 0;
    if (m_known) begin
      e.tag   = tag;
      e.ready = m_ready();
      e.lc    = m_lc;
      e.sc    = m_sc;
      e.mis   = m_mis;
      e.rng   = m_rng;
      e.con   = m_con;
      e.drive = m_ready() && ld && !st;
      e.data  = in_rng ? m_mem[idx] : 32'h0;
      exp_q.push_back(e);
    end
    // Model the coming edge.
    if (rst) begin
      m_known     = 1;
      m_init_left = WORDS;
      m_lc = 0; m_sc = 0;
      m_mis = 0; m_rng = 0; m_con = 0;
      foreach (m_mem[i]) m_mem[i] = 32'h0;
    end else if (m_known) begin
      if (!m_ready()) begin
        if (ld || st) m_con = 1;
        m_init_left--;
      end else if (ld && st) begin
        m_con = 1;
      end else if (ld || st) begin
        if (addr[1:0] != 2'b00) m_mis = 1;
        if (!in_rng) begin
          m_rng = 1;
        end else if (st) begin
          m_mem[idx] = wdata;
          m_sc++;
        end else begin
          m_lc++;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc("idle", 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    cyc("reset", 1, 0, 0, 32'h0, 32'h0);
    cyc("reset", 1, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          r;
    int          wait_cnt;
    reset = 1; load = 0; store = 0; daddrbus = 0; cpu_data = 0; cpu_drive = 0;

    // Reset and INIT timing; every idle cycle checks ready against the model.
    do_reset();
    idle(64);
    cyc("load_after_init", 0, 1, 0, 32'h0000_00F0, 32'h0);

    // Store then immediate load of the same word.
    cyc("store_beef", 0, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF);
    cyc("load_beef",  0, 1, 0, 32'h0000_0010, 32'h0);
    idle(1);

    // Out-of-range load and store; word 0 must stay intact.
    cyc("store_w0",   0, 0, 1, 32'h0000_0000, 32'h1234_5678);
    cyc("load_oor",   0, 1, 0, 32'h0000_0100, 32'h0);
    cyc("store_oor",  0, 0, 1, 32'h0000_0100, 32'hFFFF_FFFF);
    cyc("load_w0",    0, 1, 0, 32'h0000_0000, 32'h0);

    // Conflict and misaligned load.
    cyc("store_w2",   0, 0, 1, 32'h0000_0008, 32'hA5A5_0002);
    cyc("conflict",   0, 1, 1, 32'h0000_0008, 32'h5555_5555);
    cyc("load_mis",   0, 1, 0, 32'h0000_0009, 32'h0);
    idle(1);

    // Store during INIT is ignored.
    do_reset();
    idle(10);
    cyc("store_init", 0, 0, 1, 32'h0000_0004, 32'hCAFE_F00D);
    idle(60);
    cyc("load_w1_init", 0, 1, 0, 32'h0000_0004, 32'h0);

    // Reset mid-RUN after a store clears the word again.
    cyc("store_w1",   0, 0, 1, 32'h0000_0004, 32'h0BAD_F00D);
    cyc("load_w1",    0, 1, 0, 32'h0000_0004, 32'h0);
    do_reset();
    cyc("load_in_init", 0, 1, 0, 32'h0000_0004, 32'h0);
    idle(64);
    cyc("load_w1_clr", 0, 1, 0, 32'h0000_0004, 32'h0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      a = {24'h0, 6'($urandom_range(0, WORDS - 1)), 2'b00};
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) a[31:8] = 24'($urandom_range(1, 32'h00FF_FFFF));
      d = $urandom;
      if (r < 3)        do_reset();
      else if (r < 400) cyc("rnd_load",  0, 1, 0, a, d);
      else if (r < 800) cyc("rnd_store", 0, 0, 1, a, d);
      else if (r < 850) cyc("rnd_both",  0, 1, 1, a, d);
      else              cyc("rnd_idle",  0, 0, 0, a, d);
    end

    // Store counter wrap: 65536 accepted stores from zero.
    do_reset();
    idle(64);
    for (int i = 0; i < 65536; i++) begin
      cyc("wrap_store", 0, 0, 1, {24'h0, 6'(i), 2'b00}, 32'(i));
    end
    cyc("wrap_done", 0, 0, 0, 32'h0, 32'h0);
    cyc("wrap_load", 0, 1, 0, 32'h0000_00FC, 32'h0);

    // Drain the scoreboard with a bounded wait.
    cyc("drain", 0, 0, 0, 32'h0, 32'h0);
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    #1;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have one parameter: ADDR_BITS, default 6, word-index width; the array holds 2^ADDR_BITS 32-bit words.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port daddrbus, input, 32 bits: byte address from the CPU EX/MEM stage.
REQ-005 The block SHALL have port databus, inout, 32 bits: shared data bus; the CPU drives it on store, this block drives it on load.
REQ-006 The block SHALL have port load, input, 1 bit: read request for the current cycle.
REQ-007 The block SHALL have port store, input, 1 bit: write request; write data is on databus in the same cycle.
REQ-008 The block SHALL have port ready, output, 1 bit: high only in RUN state.
REQ-009 The block SHALL have port err_misalign, output, 1 bit: sticky; an access had daddrbus[1:0] != 0.
REQ-010 The block SHALL have port err_range, output, 1 bit: sticky; an access had daddrbus[31:ADDR_BITS+2] != 0.
REQ-011 The block SHALL have port err_conflict, output, 1 bit: sticky; load and store were high together, or any access occurred while not ready.
REQ-012 The block SHALL have port load_count, output, 16 bits: count of accepted loads.
REQ-013 The block SHALL have port store_count, output, 16 bits: count of accepted stores.

Function
REQ-014 The block SHALL implement an FSM with two states: INIT and RUN.
REQ-015 In INIT, the block SHALL write 0 to array[init_idx] and increment init_idx each cycle; after writing index 2^ADDR_BITS-1 it SHALL enter RUN on the next edge (INIT lasts exactly 2^ADDR_BITS cycles).
REQ-016 RUN SHALL be held until reset; no other transition exists.
REQ-017 The word index SHALL be daddrbus[ADDR_BITS+1:2]; bits [1:0] are ignored for indexing.
REQ-018 An accepted access SHALL require ready=1, exactly one of load/store high, and an in-range address; misaligned addresses are still accepted (bits [1:0] dropped).
REQ-019 Accepted store: array[index] SHALL take databus at the rising edge; store_count SHALL increment by 1.
REQ-020 Accepted load: the block SHALL drive array[index] onto databus combinationally in the same cycle (zero-cycle latency; the CPU samples at the next edge); load_count SHALL increment by 1 at that edge.
REQ-021 Load in RUN with an out-of-range address: the block SHALL drive 32'h00000000, set err_range, and leave load_count unchanged.
REQ-022 Store with an out-of-range address: no array write, err_range set, store_count unchanged.
REQ-023 The block SHALL drive databus only when load=1, store=0 and ready=1; otherwise databus is high-Z from this block.
REQ-024 load=1 and store=1 together: no drive, no write, counts unchanged, err_conflict set.
REQ-025 Any load or store while ready=0: ignored, err_conflict set; INIT progress is unaffected.
REQ-026 Counters SHALL wrap 16'hFFFF -> 16'h0000 without a flag.
REQ-027 Sticky flags SHALL clear only on reset.
REQ-028 Back-to-back store then load to the same index SHALL return the stored value (the write commits before the next cycle's read).

Reset
REQ-029 reset=1 at an edge SHALL give: state INIT, init_idx=0, ready=0, all err_* = 0, load_count = store_count = 0, databus high-Z; this applies mid-INIT or mid-RUN, and re-clears the array.
REQ-030 Array contents SHALL NOT be defined before the first INIT completes.

Verification
REQ-031 Reset, then count cycles: ready rises exactly 64 edges after reset deasserts (ADDR_BITS=6); any load then returns 0.
REQ-032 Store 32'hDEADBEEF at addr 0x0000_0010, then load 0x10 next cycle -> databus=DEADBEEF, store_count=1, load_count=1.
REQ-033 Load at 0x0000_0100 -> databus=0, err_range=1, load_count unchanged; store there -> array unchanged.
REQ-034 load=store=1 at 0x8 -> databus not driven by block, err_conflict=1; load at 0x9 -> word at index 2 returned, err_misalign=1.
REQ-035 Store during INIT -> ignored, err_conflict=1; reset mid-RUN after a store to 0x4 -> flags and counts 0, ready low for 64 cycles, load 0x4 then returns 0.
REQ-036 Force store_count to 16'hFFFF via 65535 stores, one more store -> 16'h0000.
